// File: rtl/recovery_sequencer_pkg.sv
// Shared types and helpers for branch-misprediction recovery.
// branch_is_older is also used by the ROB, so it takes fixed-width zero-extended ids.
package recovery_sequencer_pkg;

   localparam int BRANCH_ID_MAX_WIDTH = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FLUSH,
      ST_RESTORE,
      ST_REDIRECT,
      ST_SETTLE
   } recovery_state_t;

   // Tags wrap with a color bit: same color compares directly, a color flip inverts the order.
   function automatic logic branch_is_older(
      input logic [BRANCH_ID_MAX_WIDTH-1:0] id_a,
      input logic                           color_a,
      input logic [BRANCH_ID_MAX_WIDTH-1:0] id_b,
      input logic                           color_b
   );
      if (color_a == color_b)
         return id_a < id_b;
      else
         return id_a > id_b;
   endfunction

endpackage

// File: rtl/recovery_sequencer_sat_counter32.sv
// Increment-enabled 32-bit counter that sticks at all-ones.
module sat_counter32 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc,
   output logic [31:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (inc && (count != 32'hFFFF_FFFF))
         count <= count + 32'd1;
   end

endmodule

// File: rtl/recovery_sequencer.sv
// Misprediction recovery FSM: flush, checkpoint restore handshake, PC redirect, settle.
// Also arbitrates load_pc between recovery and decode redirects and keeps statistics.
module recovery_sequencer
   import recovery_sequencer_pkg::*;
#(
   parameter int ADDR_WIDTH      = 32,
   parameter int BRANCH_ID_WIDTH = 4,
   parameter int FLUSH_CYCLES    = 1,
   parameter int SETTLE_CYCLES   = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       mispredict_valid,
   input  logic [ADDR_WIDTH-1:0]      mispredict_target,
   input  logic [BRANCH_ID_WIDTH-1:0] mispredict_branch_id,
   input  logic                       mispredict_color,
   input  logic                       dec_redirect_valid,
   input  logic [ADDR_WIDTH-1:0]      dec_redirect_target,
   input  logic                       restore_ack,
   output logic                       restore_req,
   output logic [BRANCH_ID_WIDTH-1:0] restore_branch_id,
   output logic                       restore_color,
   output logic                       flush_front,
   output logic                       front_stall,
   output logic                       load_pc_we,
   output logic [ADDR_WIDTH-1:0]      load_pc_new_pc,
   output logic                       busy,
   output logic [31:0]                recovery_count,
   output logic [31:0]                recovery_cycles
);

   localparam logic [3:0] FLUSH_LOAD  = 4'(FLUSH_CYCLES - 1);
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   recovery_state_t              state_reg, state_next;
   logic [3:0]                   cnt_reg, cnt_next;
   logic [ADDR_WIDTH-1:0]        target_reg, target_next;
   logic [BRANCH_ID_WIDTH-1:0]   id_reg, id_next;
   logic                         color_reg, color_next;
   logic                         capture;
   logic                         new_is_older;

   assign new_is_older = branch_is_older(BRANCH_ID_MAX_WIDTH'(mispredict_branch_id), mispredict_color,
                                         BRANCH_ID_MAX_WIDTH'(id_reg), color_reg);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= ST_IDLE;
         cnt_reg    <= '0;
         target_reg <= '0;
         id_reg     <= '0;
         color_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         target_reg <= target_next;
         id_reg     <= id_next;
         color_reg  <= color_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      capture        = 1'b0;
      restore_req    = 1'b0;
      flush_front    = 1'b0;
      front_stall    = 1'b0;
      load_pc_we     = 1'b0;
      load_pc_new_pc = '0;

      unique case (state_reg)
         ST_IDLE: begin
            // rst_n gates the input-driven outputs so everything reads 0 while reset is held
            if (mispredict_valid && rst_n) begin
               flush_front = 1'b1;
               capture     = 1'b1;
            end else if (dec_redirect_valid && rst_n) begin
               load_pc_we     = 1'b1;
               load_pc_new_pc = dec_redirect_target;
            end
         end
         ST_FLUSH: begin
            flush_front = 1'b1;
            front_stall = 1'b1;
            if (mispredict_valid && new_is_older)
               capture = 1'b1;
            else if (cnt_reg == 4'd0)
               state_next = ST_RESTORE;
            else
               cnt_next = cnt_reg - 4'd1;
         end
         ST_RESTORE: begin
            flush_front = 1'b1;
            front_stall = 1'b1;
            restore_req = 1'b1;
            if (mispredict_valid && new_is_older)
               capture = 1'b1;
            else if (restore_ack)
               state_next = ST_REDIRECT;
         end
         ST_REDIRECT: begin
            flush_front    = 1'b1;
            load_pc_we     = 1'b1;
            load_pc_new_pc = target_reg;
            if (mispredict_valid) begin
               capture = 1'b1;
            end else if (SETTLE_CYCLES == 0) begin
               state_next = ST_IDLE;
            end else begin
               state_next = ST_SETTLE;
               cnt_next   = SETTLE_LOAD;
            end
         end
         ST_SETTLE: begin
            front_stall = 1'b1;
            if (mispredict_valid)
               capture = 1'b1;
            else if (cnt_reg == 4'd0)
               state_next = ST_IDLE;
            else
               cnt_next = cnt_reg - 4'd1;
         end
         default: state_next = ST_IDLE;
      endcase

      if (capture) begin
         state_next = ST_FLUSH;
         cnt_next   = FLUSH_LOAD;
      end
   end

   assign target_next       = capture ? mispredict_target    : target_reg;
   assign id_next           = capture ? mispredict_branch_id : id_reg;
   assign color_next        = capture ? mispredict_color     : color_reg;
   assign restore_branch_id = restore_req ? id_reg : '0;
   assign restore_color     = restore_req & color_reg;
   assign busy              = (state_reg != ST_IDLE);

   sat_counter32 u_count (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (state_reg == ST_REDIRECT),
      .count (recovery_count)
   );

   sat_counter32 u_cycles (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (busy),
      .count (recovery_cycles)
   );

endmodule

// File: tb/tb_recovery_sequencer.sv
// Directed bench for recovery_sequencer with default parameters; cycle 0 is the mispredict cycle.
module tb_recovery_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mispredict_valid;
   logic [31:0] mispredict_target;
   logic [3:0]  mispredict_branch_id;
   logic        mispredict_color;
   logic        dec_redirect_valid;
   logic [31:0] dec_redirect_target;
   logic        restore_ack;
   logic        restore_req;
   logic [3:0]  restore_branch_id;
   logic        restore_color;
   logic        flush_front;
   logic        front_stall;
   logic        load_pc_we;
   logic [31:0] load_pc_new_pc;
   logic        busy;
   logic [31:0] recovery_count;
   logic [31:0] recovery_cycles;

   int checks = 0;
   int errors = 0;

   recovery_sequencer dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .mispredict_valid     (mispredict_valid),
      .mispredict_target    (mispredict_target),
      .mispredict_branch_id (mispredict_branch_id),
      .mispredict_color     (mispredict_color),
      .dec_redirect_valid   (dec_redirect_valid),
      .dec_redirect_target  (dec_redirect_target),
      .restore_ack          (restore_ack),
      .restore_req          (restore_req),
      .restore_branch_id    (restore_branch_id),
      .restore_color        (restore_color),
      .flush_front          (flush_front),
      .front_stall          (front_stall),
      .load_pc_we           (load_pc_we),
      .load_pc_new_pc       (load_pc_new_pc),
      .busy                 (busy),
      .recovery_count       (recovery_count),
      .recovery_cycles      (recovery_cycles)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      mispredict_valid     = 1'b0;
      mispredict_target    = '0;
      mispredict_branch_id = '0;
      mispredict_color     = 1'b0;
      dec_redirect_valid   = 1'b0;
      dec_redirect_target  = '0;
      restore_ack          = 1'b0;
   endtask

   task automatic set_mp(input logic [31:0] tgt, input logic [3:0] id, input logic col);
      mispredict_valid     = 1'b1;
      mispredict_target    = tgt;
      mispredict_branch_id = id;
      mispredict_color     = col;
   endtask

   task automatic check_all_zero(input string pfx);
      check({pfx, "_req"},    restore_req,       0);
      check({pfx, "_id"},     restore_branch_id, 0);
      check({pfx, "_color"},  restore_color,     0);
      check({pfx, "_flush"},  flush_front,       0);
      check({pfx, "_stall"},  front_stall,       0);
      check({pfx, "_we"},     load_pc_we,        0);
      check({pfx, "_pc"},     load_pc_new_pc,    0);
      check({pfx, "_busy"},   busy,              0);
      check({pfx, "_count"},  recovery_count,    0);
      check({pfx, "_cycles"}, recovery_cycles,   0);
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      #12;
      check_all_zero("reset");
      tick();
      rst_n = 1'b1;
      tick();

      // Basic recovery: ack two cycles after the request, redirect at cycle 5
      for (int c = 0; c < 10; c++) begin
         clear_inputs();
         if (c == 0) set_mp(32'h0040_0100, 4'd3, 1'b0);
         restore_ack = (c == 4);
         #1;
         check("basic_busy",  busy,        (c >= 1 && c <= 7));
         check("basic_we",    load_pc_we,  (c == 5));
         check("basic_pc",    load_pc_new_pc, (c == 5) ? 32'h0040_0100 : 32'h0);
         check("basic_req",   restore_req, (c >= 2 && c <= 4));
         check("basic_rid",   restore_branch_id, (c >= 2 && c <= 4) ? 4'd3 : 4'd0);
         check("basic_flush", flush_front, (c <= 5));
         check("basic_stall", front_stall, (c >= 1 && c <= 4) || c == 6 || c == 7);
         tick();
      end
      clear_inputs();
      check("basic_count",  recovery_count,  1);
      check("basic_cycles", recovery_cycles, 7);

      // Older nested mispredict during RESTORE restarts the flush with id 2
      for (int c = 0; c < 10; c++) begin
         clear_inputs();
         if (c == 0) set_mp(32'h0000_1000, 4'd5, 1'b0);
         if (c == 2) set_mp(32'h0000_2000, 4'd2, 1'b0);
         restore_ack = (c == 4);
         #1;
         check("nest_req",  restore_req, (c == 2 || c == 4));
         check("nest_rid",  restore_branch_id, (c == 2) ? 4'd5 : (c == 4) ? 4'd2 : 4'd0);
         check("nest_we",   load_pc_we, (c == 5));
         check("nest_pc",   load_pc_new_pc, (c == 5) ? 32'h0000_2000 : 32'h0);
         check("nest_busy", busy, (c >= 1 && c <= 7));
         tick();
      end
      clear_inputs();
      check("nest_count", recovery_count, 2);

      // Younger mispredict during FLUSH ignored; decode redirect during SETTLE dropped
      for (int c = 0; c < 8; c++) begin
         clear_inputs();
         if (c == 0) set_mp(32'h0000_3000, 4'd2, 1'b0);
         if (c == 1) set_mp(32'h0000_4000, 4'd6, 1'b0);
         restore_ack = (c == 2);
         if (c == 4) begin
            dec_redirect_valid  = 1'b1;
            dec_redirect_target = 32'h80;
         end
         #1;
         check("young_req",  restore_req, (c == 2));
         check("young_rid",  restore_branch_id, (c == 2) ? 4'd2 : 4'd0);
         check("young_we",   load_pc_we, (c == 3));
         check("young_pc",   load_pc_new_pc, (c == 3) ? 32'h0000_3000 : 32'h0);
         check("young_busy", busy, (c >= 1 && c <= 5));
         tick();
      end
      clear_inputs();

      // Decode redirect honored in IDLE, same cycle
      dec_redirect_valid  = 1'b1;
      dec_redirect_target = 32'h80;
      #1;
      check("dec_we",    load_pc_we, 1);
      check("dec_pc",    load_pc_new_pc, 32'h80);
      check("dec_flush", flush_front, 0);
      tick();
      clear_inputs();
      #1;
      check("dec_we_off", load_pc_we, 0);
      check("dec_busy",   busy, 0);
      tick();

      // Mispredict and decode redirect together: mispredict wins
      for (int c = 0; c < 8; c++) begin
         clear_inputs();
         if (c == 0) begin
            set_mp(32'h0000_5000, 4'd1, 1'b1);
            dec_redirect_valid  = 1'b1;
            dec_redirect_target = 32'h80;
         end
         restore_ack = (c == 2);
         #1;
         check("simul_we",    load_pc_we, (c == 3));
         check("simul_pc",    load_pc_new_pc, (c == 3) ? 32'h0000_5000 : 32'h0);
         check("simul_flush", flush_front, (c <= 3));
         check("simul_color", restore_color, (c == 2));
         check("simul_busy",  busy, (c >= 1 && c <= 5));
         tick();
      end
      clear_inputs();
      check("simul_count", recovery_count, 4);

      // Reset while waiting in RESTORE
      set_mp(32'h0000_6000, 4'd4, 1'b0);
      tick();
      clear_inputs();
      tick();
      check("rst_pre_req", restore_req, 1);
      rst_n = 1'b0;
      #1;
      check_all_zero("rst_mid");
      tick();
      rst_n = 1'b1;
      tick();
      for (int c = 0; c < 7; c++) begin
         clear_inputs();
         if (c == 0) set_mp(32'h0000_7000, 4'd7, 1'b0);
         restore_ack = (c == 2);
         #1;
         check("post_we",   load_pc_we, (c == 3));
         check("post_pc",   load_pc_new_pc, (c == 3) ? 32'h0000_7000 : 32'h0);
         check("post_busy", busy, (c >= 1 && c <= 5));
         tick();
      end
      clear_inputs();
      check("post_count",  recovery_count,  1);
      check("post_cycles", recovery_cycles, 5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
